// File: rtl/fgmt_ibuf.sv
// fgmt_ibuf: multi-thread, multi-line L1 instruction buffer.
//
// Each hardware thread owns LINES fully-associative lines. A fetch looks up the
// selected thread and returns the instruction one cycle later. Misses, next-line
// prefetches and branch targets become per-thread pending requests. A round-robin
// arbiter issues them one at a time to L2, and L2 responses are installed.
//
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   fetch_valid/fetch_tid/fetch_pc    lookup request for one thread
//   instr_valid/instr/instr_tid       registered lookup result (BUBBLE on miss/idle)
//   br_valid/br_tid/br_target         branch redirect, fetches the target line if absent
//   l2_req_valid/ready/addr/tid/spec  line request channel to L2
//   l2_rsp_valid/tid/addr/line        line response from L2
//
// Handshake: a request transfers on a rising edge where l2_req_valid and
// l2_req_ready are both high. Once l2_req_valid is raised, addr/tid/spec stay
// unchanged until that transfer. A new request is presented no earlier than
// the cycle after the transfer.
module fgmt_ibuf #(
  parameter int          NTHREADS = 4,
  parameter int          LINES    = 2,
  parameter int          WORDS    = 4,
  parameter logic [31:0] BUBBLE   = 32'h00000013,
  localparam int         TW       = $clog2(NTHREADS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [TW-1:0]         fetch_tid,
  input  logic [31:0]           fetch_pc,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [TW-1:0]         instr_tid,
  input  logic                  br_valid,
  input  logic [TW-1:0]         br_tid,
  input  logic [31:0]           br_target,
  output logic                  l2_req_valid,
  input  logic                  l2_req_ready,
  output logic [31:0]           l2_req_addr,
  output logic [TW-1:0]         l2_req_tid,
  output logic                  l2_req_spec,
  input  logic                  l2_rsp_valid,
  input  logic [TW-1:0]         l2_rsp_tid,
  input  logic [31:0]           l2_rsp_addr,
  input  logic [32*WORDS-1:0]   l2_rsp_line
);
  localparam int OFF = $clog2(WORDS * 4);
  localparam int AW  = 32 - OFF;
  localparam int WIW = OFF - 2;
  localparam int LW  = (LINES > 1) ? $clog2(LINES) : 1;

  // Slot state per thread; the encoding is {outstanding, pending}.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_PEND     = 2'b01,
    S_OUT      = 2'b10,
    S_OUT_PEND = 2'b11
  } slot_e;

  logic [NTHREADS-1:0][LINES-1:0] vld;
  logic [AW-1:0]       tags      [NTHREADS][LINES];
  logic [32*WORDS-1:0] data      [NTHREADS][LINES];
  logic [LW-1:0]       rptr      [NTHREADS];
  slot_e               slot_q    [NTHREADS];
  logic [AW-1:0]       pend_addr [NTHREADS];
  logic [AW-1:0]       outs_addr [NTHREADS];
  logic [NTHREADS-1:0] pend_spec;
  logic [TW-1:0]       arb_ptr;

  logic [NTHREADS-1:0] pend, outs, pend_n, outs_n, new_req, new_spec, hs;
  logic [AW-1:0]       new_addr [NTHREADS];

  wire [AW-1:0]  f_tag  = fetch_pc[31:OFF];
  wire [WIW-1:0] f_widx = fetch_pc[OFF-1:2];
  wire [AW-1:0]  p_tag  = f_tag + AW'(1);
  wire [AW-1:0]  b_tag  = br_target[31:OFF];
  wire [AW-1:0]  r_tag  = l2_rsp_addr[31:OFF];
  wire [AW-1:0]  q_tag  = l2_req_addr[31:OFF];
  wire unused_addr_bits = ^{fetch_pc[1:0], br_target[OFF-1:0], l2_rsp_addr[OFF-1:0]};

  logic [LINES-1:0] f_hit_vec, p_hit_vec, b_hit_vec, r_hit_vec;
  logic [31:0]      f_word;
  logic [LW-1:0]    r_idx;
  logic             f_hit, r_hit, fill_ok, dem, pf, brq;
  logic             sel_found;
  logic [TW-1:0]    sel_tid, cand;

  always_comb begin
    for (int t = 0; t < NTHREADS; t++) begin
      pend[t] = (slot_q[t] == S_PEND) || (slot_q[t] == S_OUT_PEND);
      outs[t] = (slot_q[t] == S_OUT)  || (slot_q[t] == S_OUT_PEND);
    end
  end

  // Tag compares: fetch line, its successor, branch target and response line.
  always_comb begin
    f_hit_vec = '0;
    p_hit_vec = '0;
    b_hit_vec = '0;
    r_hit_vec = '0;
    f_word    = BUBBLE;
    r_idx     = rptr[l2_rsp_tid];
    for (int l = 0; l < LINES; l++) begin
      f_hit_vec[l] = vld[fetch_tid][l]  && (tags[fetch_tid][l]  == f_tag);
      p_hit_vec[l] = vld[fetch_tid][l]  && (tags[fetch_tid][l]  == p_tag);
      b_hit_vec[l] = vld[br_tid][l]     && (tags[br_tid][l]     == b_tag);
      r_hit_vec[l] = vld[l2_rsp_tid][l] && (tags[l2_rsp_tid][l] == r_tag);
      if (f_hit_vec[l]) f_word = data[fetch_tid][l][32*int'(f_widx) +: 32];
      if (r_hit_vec[l]) r_idx = LW'(l);
    end
    f_hit   = |f_hit_vec;
    r_hit   = |r_hit_vec;
    fill_ok = l2_rsp_valid && outs[l2_rsp_tid] && (outs_addr[l2_rsp_tid] == r_tag);
  end

  // New pending requests and next slot state per thread.
  always_comb begin
    dem = fetch_valid && !f_hit
          && !(outs[fetch_tid] && (outs_addr[fetch_tid] == f_tag))
          && !(pend[fetch_tid] && (pend_addr[fetch_tid] == f_tag))
          && (!pend[fetch_tid] || pend_spec[fetch_tid]);
    pf  = fetch_valid && f_hit && (f_widx == WIW'(WORDS - 1)) && !(|p_hit_vec)
          && !pend[fetch_tid]
          && !(outs[fetch_tid] && (outs_addr[fetch_tid] == p_tag));
    brq = br_valid && !(|b_hit_vec);
    for (int t = 0; t < NTHREADS; t++) begin
      new_req[t]  = 1'b0;
      new_spec[t] = 1'b0;
      new_addr[t] = f_tag;
      hs[t]       = l2_req_valid && l2_req_ready && (l2_req_tid == TW'(t));
      if (brq && (br_tid == TW'(t))) begin
        new_req[t]  = 1'b1;
        new_addr[t] = b_tag;
      end else if (dem && (fetch_tid == TW'(t))) begin
        new_req[t]  = 1'b1;
      end else if (pf && (fetch_tid == TW'(t))) begin
        new_req[t]  = 1'b1;
        new_addr[t] = p_tag;
        new_spec[t] = 1'b1;
      end
      outs_n[t] = (outs[t] && !(fill_ok && (l2_rsp_tid == TW'(t)))) || hs[t];
      // A pending entry rewritten while it was being presented survives the
      // transfer; only the entry that was actually sent is retired.
      if (new_req[t])                              pend_n[t] = 1'b1;
      else if (hs[t] && (pend_addr[t] == q_tag))   pend_n[t] = 1'b0;
      else                                         pend_n[t] = pend[t];
    end
  end

  // Round-robin pick, starting with the thread after the last grant.
  always_comb begin
    sel_found = 1'b0;
    sel_tid   = arb_ptr;
    cand      = '0;
    for (int i = 1; i <= NTHREADS; i++) begin
      cand = arb_ptr + TW'(i);
      if (!sel_found && pend[cand] && !outs[cand]) begin
        sel_found = 1'b1;
        sel_tid   = cand;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld          <= '0;
      pend_spec    <= '0;
      arb_ptr      <= '0;
      l2_req_valid <= 1'b0;
      l2_req_addr  <= '0;
      l2_req_tid   <= '0;
      l2_req_spec  <= 1'b0;
      instr_valid  <= 1'b0;
      instr        <= BUBBLE;
      instr_tid    <= '0;
      for (int t = 0; t < NTHREADS; t++) begin
        slot_q[t]    <= S_IDLE;
        rptr[t]      <= '0;
        pend_addr[t] <= '0;
        outs_addr[t] <= '0;
      end
    end else begin
      instr_valid <= fetch_valid && f_hit;
      instr       <= (fetch_valid && f_hit) ? f_word : BUBBLE;
      instr_tid   <= fetch_tid;

      if (l2_req_valid) begin
        if (l2_req_ready) l2_req_valid <= 1'b0;
      end else if (sel_found) begin
        l2_req_valid <= 1'b1;
        l2_req_addr  <= {pend_addr[sel_tid], {OFF{1'b0}}};
        l2_req_tid   <= sel_tid;
        l2_req_spec  <= pend_spec[sel_tid];
        arb_ptr      <= sel_tid;
      end

      for (int t = 0; t < NTHREADS; t++) begin
        slot_q[t] <= slot_e'({outs_n[t], pend_n[t]});
        if (hs[t]) outs_addr[t] <= q_tag;
        if (new_req[t]) begin
          pend_addr[t] <= new_addr[t];
          pend_spec[t] <= new_spec[t];
        end
      end

      // A refill of a resident line overwrites it in place and keeps the
      // replacement pointer where it is.
      if (fill_ok) begin
        vld[l2_rsp_tid][r_idx]  <= 1'b1;
        tags[l2_rsp_tid][r_idx] <= r_tag;
        data[l2_rsp_tid][r_idx] <= l2_rsp_line;
        if (!r_hit)
          rptr[l2_rsp_tid] <= (rptr[l2_rsp_tid] == LW'(LINES - 1)) ? '0
                              : rptr[l2_rsp_tid] + LW'(1);
      end
    end
  end
endmodule

// File: doc/fgmt_ibuf.md
Name: fgmt_ibuf

Overview:
- Multi-thread, multi-line L1 instruction buffer for the fine-grained multithreaded core. Generalises the single-line, single-thread refill buffer.
- Holds LINES lines per hardware thread and serves fetch from the thread selected each cycle.
- Arbitrates refill, prefetch and branch line requests from all threads onto one valid/ready request channel to L2, and installs L2 responses.

Parameters:
NTHREADS, 4, number of hardware threads (power of 2, >=2)
LINES, 2, lines held per thread (power of 2, >=1)
WORDS, 4, 32-bit words per line (power of 2, >=2)
BUBBLE, 32'h00000013, instruction word emitted on miss or idle

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
fetch_valid  in  1  fetch lookup this cycle
fetch_tid  in  log2(NTHREADS)  thread being fetched
fetch_pc  in  32  fetch address, word aligned
instr_valid  out  1  registered: instr holds a hit
instr  out  32  registered instruction, BUBBLE when not valid
instr_tid  out  log2(NTHREADS)  thread of instr
br_valid  in  1  branch redirect
br_tid  in  log2(NTHREADS)  redirected thread
br_target  in  32  branch target address
l2_req_valid  out  1  line request to L2
l2_req_ready  in  1  L2 accepts request
l2_req_addr  out  32  line-aligned request address
l2_req_tid  out  log2(NTHREADS)  requesting thread
l2_req_spec  out  1  1 = prefetch, 0 = demand/branch
l2_rsp_valid  in  1  L2 response valid
l2_rsp_tid  in  log2(NTHREADS)  response thread
l2_rsp_addr  in  32  response line address
l2_rsp_line  in  32*WORDS  line data, word 0 in bits [31:0]

Behaviour:
- One clock, `clock`. `reset` is synchronous, active-high.
- Reset:
  - All valid bits, pending and outstanding flags clear.
  - Replacement pointers go to 0.
  - Arbiter pointer goes to 0.
  - instr_valid=0, instr=BUBBLE, instr_tid=0, l2_req_valid=0.
- Address split:
  - OFF = log2(WORDS*4).
  - tag = addr[31:OFF], word index = addr[OFF-1:2].
- Lookup:
  - Compares fetch_pc tag against all LINES entries of fetch_tid using valid tags only.
  - Outputs are registered, so latency is 1 cycle.
  - Hit: instr_valid=1 and instr is the indexed word.
  - Miss, or fetch_valid=0: instr_valid=0 and instr=BUBBLE.
- Per-thread request slot. Each thread holds at most one of each:
  - pending: not yet issued; holds addr and spec.
  - outstanding: issued to L2, awaiting response; holds addr.
- Slot FSM per thread:
  - IDLE -> PEND on a new request.
  - PEND -> OUT on the request handshake.
  - OUT -> IDLE on a matching response.
  - OUT plus a new pending request is allowed. After the response, the slot returns to PEND, not IDLE.
- Demand miss:
  - Creates a pending request with spec=0.
  - Suppressed if its line equals the outstanding or pending addr of that thread.
  - Overwrites a pending prefetch. A pending demand is never overwritten by a prefetch.
- Prefetch:
  - Triggered by a hit on word index WORDS-1.
  - Target is line tag+1, wrapping at 2^(32-OFF).
  - Creates a pending spec=1 request only if that line is not resident, the thread has no pending request, and the line is not outstanding.
- Branch (br_valid):
  - If br_target's line is not resident in br_tid, sets pending to the target line with spec=0, overriding any pending request.
  - The outstanding request is not cancelled.
  - If br_tid==fetch_tid in the same cycle and both create a pending request, the branch wins.
- Arbiter:
  - Round-robin over threads with pending requests, starting after the last granted thread.
  - Presents one request at a time.
  - l2_req_* are registered and held stable until l2_req_ready.
  - A thread with an outstanding request is not eligible.
  - If a branch overrides the pending request of the thread being presented, the presented request is still completed unchanged; the new pending request waits.
- Fill (l2_rsp_valid):
  - Installs into thread l2_rsp_tid only if l2_rsp_addr's line equals that thread's outstanding addr. Otherwise the response is dropped with no state change.
  - If the line is already resident, it overwrites that entry. Otherwise it writes the entry at the thread's replacement pointer, then increments the pointer modulo LINES.
  - The fill is visible to lookup from the next cycle; there is no bypass.
  - A same-cycle lookup of that line misses, but is suppressed by the outstanding match.
- Simultaneous request handshake and response for the same thread cannot occur, since at most one request is outstanding per thread.
- Reset asserted mid-request: all state is dropped; late L2 responses are discarded because nothing is outstanding.

Test Plan:
- Cold miss: reset, fetch tid 1, pc 0x100 -> next cycle instr_valid=0, instr=BUBBLE; l2_req_addr=0x100, tid=1, spec=0; after response line {A,B,C,D}, fetch 0x104 -> instr=B, instr_valid=1.
- Prefetch: line 0x100 resident in tid 0, fetch 0x10C -> instr=D, then one spec=1 request addr 0x110; repeated fetch of 0x10C -> no duplicate request.
- Arbitration: misses on tids 0, 2, 3 in one cycle sequence with l2_req_ready held low 3 cycles -> l2_req_addr stable while low; then grants occur in order 0, 2, 3.
- Replacement (LINES=2): fill 0x100, 0x200, 0x300 into tid 0 -> 0x100 evicted; 0x200 and 0x300 hit.
- Branch override: pending prefetch 0x110 for tid 2, br_target 0x400 -> next issued request is 0x400 with spec=0; a branch to a resident line issues no request.
- Stale/mismatched response: response tid 1 addr 0x500 with outstanding 0x100 -> dropped, no hit on 0x500; reset during outstanding, then response -> dropped, l2_req_valid=0.
